// File: rtl/mux_rr_fifo_nx1_pkg.sv
// Shared constants and helpers for the round-robin N-to-1 FIFO mux.
package mux_rr_fifo_nx1_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_AF_TH      = 3;

    // Ceiling log2. The result is never below 1, so a derived index field
    // always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_rr_fifo_nx1_if.sv
// Upstream write lanes and downstream output port of the N-to-1 FIFO mux.
interface mux_rr_fifo_nx1_if
    import mux_rr_fifo_nx1_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    localparam int CH_W  = clog2(NUM_CH)
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_full;
    logic [NUM_CH-1:0]        err_overflow;
    logic                     out_pause;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;

    // Byte sources and the downstream stage
    modport master (
        output in_valid, in_data, out_pause,
        input  in_full, err_overflow, out_valid, out_data, out_ch
    );

    // The mux itself
    modport slave (
        input  in_valid, in_data, out_pause,
        output in_full, err_overflow, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/mux_rr_fifo_nx1_fifo_sync_n.sv
// Single-clock FIFO with a combinational head and a sticky overflow flag.
// A push into a full FIFO succeeds when the same cycle pops it.
module fifo_sync_n
    import mux_rr_fifo_nx1_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W     = clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers, occupancy and the sticky overflow flag
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage array
    // NOTE: no reset here; pointers and count decide which words are live, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/mux_rr_fifo_nx1.sv
// N-to-1 mux: per-channel FIFOs, a round-robin arbiter and a registered
// output stage with downstream pause.
module mux_rr_fifo_nx1
    import mux_rr_fifo_nx1_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_TH      = DEF_AF_TH,
    localparam int CH_W      = clog2(NUM_CH),
    localparam int CNT_W     = clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_L,
    mux_rr_fifo_nx1_if.slave  bus
);
    logic [NUM_CH-1:0] fifo_pop;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_ovf;
    logic [DATA_W-1:0] fifo_head  [NUM_CH];
    logic [CNT_W-1:0]  fifo_count [NUM_CH];

    logic [CH_W-1:0]   last_grant;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic [DATA_W-1:0] grant_data;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fifo_sync_n #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset_L  (reset_L),
            .push     (bus.in_valid[i]),
            .pop      (fifo_pop[i]),
            .din      (bus.in_data[i*DATA_W +: DATA_W]),
            .dout     (fifo_head[i]),
            .count    (fifo_count[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i]),
            .overflow (fifo_ovf[i])
        );

        // Advisory only: upstream may still write, the FIFO decides on overflow.
        assign bus.in_full[i] = (fifo_count[i] >= CNT_W'(AF_TH));

        a_full_not_empty: assert property (
            @(posedge clk) disable iff (!reset_L) !(fifo_full[i] && fifo_empty[i])
        );
    end

    assign bus.err_overflow = fifo_ovf;

    // Round-robin scan starting just after the last granted channel
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        fifo_pop    = '0;
        if (!bus.out_pause) begin
            for (int off = 1; off <= NUM_CH; off++) begin
                idx = int'(last_grant) + off;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                if (!grant_valid && !fifo_empty[idx]) begin
                    grant_valid   = 1'b1;
                    grant_idx     = CH_W'(idx);
                    grant_data    = fifo_head[idx];
                    fifo_pop[idx] = 1'b1;
                end
            end
        end
    end

    // Remember the most recent winner; channel 0 leads after reset
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (grant_valid) begin
            last_grant <= grant_idx;
        end
    end

    // Output register: data and channel hold when nothing is granted
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
        end else begin
            bus.out_valid <= grant_valid;
            if (grant_valid) begin
                bus.out_data <= grant_data;
                bus.out_ch   <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_fifo_nx1.sv
// Self-checking bench for mux_rr_fifo_nx1: directed vector table, corner
// sequences and random traffic against a queue-based reference model.
module tb_mux_rr_fifo_nx1;
    import mux_rr_fifo_nx1_pkg::*;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int AF_TH      = 3;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    mux_rr_fifo_nx1_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    mux_rr_fifo_nx1 #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AF_TH      (AF_TH)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per channel plus the round-robin pointer
    logic [7:0] q [NUM_CH][$];
    int         m_lg;
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    logic [3:0] m_ovf;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic        p;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  ech;
        logic [3:0]  ef;
        logic [3:0]  eo;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [31:0] d,
                                input logic p, input logic ev, input logic [7:0] ed,
                                input logic [1:0] ech, input logic [3:0] ef, input logic [3:0] eo);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.p = p;
        r.ev = ev; r.ed = ed; r.ech = ech; r.ef = ef; r.eo = eo;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) q[i].delete();
        m_lg    = NUM_CH - 1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_ovf   = 4'h0;
    endtask

    function automatic logic [3:0] model_full();
        logic [3:0] f;
        for (int i = 0; i < NUM_CH; i++) f[i] = (q[i].size() >= AF_TH);
        return f;
    endfunction

    // Grant is decided on pre-edge occupancy, the pop frees a slot, then writes land.
    task automatic model_step(input logic [3:0] v, input logic [31:0] d, input logic p);
        int g;
        g = -1;
        if (!p) begin
            for (int off = 1; off <= NUM_CH; off++) begin
                int c;
                c = (m_lg + off) % NUM_CH;
                if (g < 0 && q[c].size() > 0) g = c;
            end
        end
        if (g >= 0) begin
            m_data  = q[g].pop_front();
            m_ch    = g;
            m_valid = 1'b1;
            m_lg    = g;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) begin
                if (q[i].size() < FIFO_DEPTH) q[i].push_back(d[i*8 +: 8]);
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic p);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_pause = p;
        model_step(v, d, p);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({tag, "_data"}, 32'(bus.out_data), 32'(m_data));
        check({tag, "_ch"}, 32'(bus.out_ch), 32'(m_ch));
        check({tag, "_full"}, 32'(bus.in_full), 32'(model_full()));
        check({tag, "_ovf"}, 32'(bus.err_overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_pause = 1'b0;
        reset_L       = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        logic [3:0]  v;
        logic [31:0] d;

        reset_L       = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_pause = 1'b0;
        model_reset();

        // Directed vectors: single word, four-way round robin, pause/overflow/drain
        tbl[0]  = mk(1, 4'h1, 32'h000000A5, 0, 0, 8'h00, 2'd0, 4'h0, 4'h0);
        tbl[1]  = mk(0, 4'h0, 32'h00000000, 0, 1, 8'hA5, 2'd0, 4'h0, 4'h0);
        tbl[2]  = mk(0, 4'h0, 32'h00000000, 0, 0, 8'hA5, 2'd0, 4'h0, 4'h0);
        tbl[3]  = mk(1, 4'hF, 32'h40302010, 0, 0, 8'h00, 2'd0, 4'h0, 4'h0);
        tbl[4]  = mk(0, 4'h0, 32'h00000000, 0, 1, 8'h10, 2'd0, 4'h0, 4'h0);
        tbl[5]  = mk(0, 4'h0, 32'h00000000, 0, 1, 8'h20, 2'd1, 4'h0, 4'h0);
        tbl[6]  = mk(0, 4'h0, 32'h00000000, 0, 1, 8'h30, 2'd2, 4'h0, 4'h0);
        tbl[7]  = mk(0, 4'h0, 32'h00000000, 0, 1, 8'h40, 2'd3, 4'h0, 4'h0);
        tbl[8]  = mk(0, 4'h0, 32'h00000000, 0, 0, 8'h40, 2'd3, 4'h0, 4'h0);
        tbl[9]  = mk(0, 4'h4, 32'h00010000, 1, 0, 8'h40, 2'd3, 4'h0, 4'h0);
        tbl[10] = mk(0, 4'h4, 32'h00020000, 1, 0, 8'h40, 2'd3, 4'h0, 4'h0);
        tbl[11] = mk(0, 4'h4, 32'h00030000, 1, 0, 8'h40, 2'd3, 4'h4, 4'h0);
        tbl[12] = mk(0, 4'h4, 32'h00040000, 1, 0, 8'h40, 2'd3, 4'h4, 4'h0);
        tbl[13] = mk(0, 4'h4, 32'h00050000, 1, 0, 8'h40, 2'd3, 4'h4, 4'h4);
        tbl[14] = mk(0, 4'h0, 32'h00000000, 0, 1, 8'h01, 2'd2, 4'h4, 4'h4);
        tbl[15] = mk(0, 4'h0, 32'h00000000, 0, 1, 8'h02, 2'd2, 4'h0, 4'h4);
        tbl[16] = mk(0, 4'h0, 32'h00000000, 0, 1, 8'h03, 2'd2, 4'h0, 4'h4);
        tbl[17] = mk(0, 4'h0, 32'h00000000, 0, 1, 8'h04, 2'd2, 4'h0, 4'h4);
        tbl[18] = mk(0, 4'h0, 32'h00000000, 0, 0, 8'h04, 2'd2, 4'h0, 4'h4);

        // Reset state
        do_reset();
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_data", 32'(bus.out_data), 32'h0);
        check("rst_ch", 32'(bus.out_ch), 32'h0);
        check("rst_full", 32'(bus.in_full), 32'h0);
        check("rst_ovf", 32'(bus.err_overflow), 32'h0);

        for (int r = 0; r < 19; r++) begin
            if (tbl[r].rst) do_reset();
            cycle(tbl[r].v, tbl[r].d, tbl[r].p);
            check($sformatf("row%0d_valid", r), 32'(bus.out_valid), 32'(tbl[r].ev));
            check($sformatf("row%0d_data", r), 32'(bus.out_data), 32'(tbl[r].ed));
            check($sformatf("row%0d_ch", r), 32'(bus.out_ch), 32'(tbl[r].ech));
            check($sformatf("row%0d_full", r), 32'(bus.in_full), 32'(tbl[r].ef));
            check($sformatf("row%0d_ovf", r), 32'(bus.err_overflow), 32'(tbl[r].eo));
        end

        // Write into a full FIFO in the cycle it is popped
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(4'h4, {8'h00, 8'hA1 + 8'(k), 16'h0000}, 1'b1);
            compare_model($sformatf("fill%0d", k));
        end
        cycle(4'h4, 32'h00990000, 1'b0);
        compare_model("popwrite");
        check("popwrite_no_ovf", 32'(bus.err_overflow), 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(4'h0, 32'h0, 1'b0);
            compare_model($sformatf("drain%0d", k));
        end
        check("last_word_99", 32'(bus.out_data), 32'h99);
        check("last_word_ch2", 32'(bus.out_ch), 32'h2);
        cycle(4'h0, 32'h0, 1'b0);
        check("drained_idle", 32'(bus.out_valid), 32'h0);

        // Two channels fed continuously with a two-cycle pause in the middle
        do_reset();
        sent = 0;
        recv = 0;
        for (int c = 0; c < 20; c++) begin
            v = 4'h0;
            d = 32'h0;
            if (c < 12 && q[1].size() < AF_TH) begin
                v[1] = 1'b1; d[15:8] = 8'h10 + 8'(c); sent++;
            end
            if (c < 12 && q[3].size() < AF_TH) begin
                v[3] = 1'b1; d[31:24] = 8'h30 + 8'(c); sent++;
            end
            cycle(v, d, (c == 3 || c == 4));
            compare_model($sformatf("feed%0d", c));
            if (bus.out_valid) recv++;
        end
        check("feed_count", 32'(recv), 32'(sent));
        check("feed_no_ovf", 32'(bus.err_overflow), 32'h0);

        // Reset asserted between edges with words still buffered
        do_reset();
        cycle(4'h3, 32'h0000B1A1, 1'b1);
        cycle(4'h3, 32'h0000B2A2, 1'b1);
        cycle(4'h0, 32'h0, 1'b0);
        compare_model("prerst");
        #2;
        reset_L = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_data", 32'(bus.out_data), 32'h0);
        check("midrst_ovf", 32'(bus.err_overflow), 32'h0);
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(4'h0, 32'h0, 1'b0);
            compare_model($sformatf("postrst%0d", k));
        end
        cycle(4'h1, 32'h00000077, 1'b0);
        cycle(4'h0, 32'h0, 1'b0);
        compare_model("postrst_word");
        check("postrst_word_77", 32'(bus.out_data), 32'h77);

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0));
            compare_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
